// File: rtl/svm_mac_pipe.sv
// svm_mac_pipe: pipelined signed fixed-point multiplier / dot-product MAC.
//   Magnitude shift-add multiply through a registered binary adder tree,
//   sign restore, rounding rescale, output clamp, and an accumulator stage
//   that reports one saturated sum per vector.
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   svm_enable        advance enable; low freezes every register
//   in_valid/last/mode operand-pair tags (mode 1 = accumulate)
//   mul_a, mul_b      DATA_W-bit two's complement operands
//   prod_valid/data   rounded, saturated product strobe
//   acc_valid/data    finished dot product strobe, acc_sat = any clamp in it
//   busy              tokens in flight or a vector is open
module svm_mac_pipe #(
  parameter int DATA_W     = 17,
  parameter int OUT_W      = 32,
  parameter int FRAC_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              svm_enable,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] mul_a,
  input  logic [DATA_W-1:0] mul_b,
  output logic              prod_valid,
  output logic [OUT_W-1:0]  prod_data,
  output logic              acc_valid,
  output logic [OUT_W-1:0]  acc_data,
  output logic              acc_sat,
  output logic              busy
);

  localparam int T      = $clog2(DATA_W);
  localparam int PW     = 2*DATA_W;
  // Index of the final product stage; S1 lives at index 0.
  localparam int STAGES = T + 3;
  localparam int XW     = (OUT_W > PW) ? OUT_W + 2 : PW + 2;
  localparam int HALF   = (DATA_W + 1) / 2;

  localparam logic        [XW-1:0]    ONE     = XW'(1);
  localparam logic signed [XW-1:0]    RND     = (ONE << FRAC_SHIFT) >> 1;
  localparam logic signed [XW-1:0]    SAT_MAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0]    SAT_MIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic last;
    logic mode;
  } tag_t;

  // Operands still alive at tree level l: ceil(DATA_W / 2^l).
  function automatic int lvl_cnt(input int l);
    return (DATA_W + (1 << l) - 1) >> l;
  endfunction

  // Two's complement magnitude; the most negative value maps to 2^(DATA_W-1)
  // which still fits as an unsigned DATA_W-bit number.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  logic [STAGES:0]      vld_pipe;
  tag_t [STAGES:0]      tag_pipe;
  logic [T+1:0]         sgn_pipe;
  logic [DATA_W-1:0]    a_mag, b_mag;
  // tree[0] = partial products, tree[l] = adder level l; extra column keeps
  // the pairwise read index in range for odd counts.
  logic [PW-1:0]        tree [0:T][0:DATA_W];
  logic signed [PW-1:0] prod_s;
  logic                 prod_sat;

  logic signed [XW-1:0]    ext, shf;
  logic [OUT_W-1:0]        rnd_q;
  logic                    rnd_sat;
  logic signed [OUT_W:0]   sum;
  logic signed [OUT_W-1:0] acc, acc_nx;
  logic                    acc_clamp, acc_flag, flag_nx, vec_open;

  // ---------------- datapath (no reset needed, tags qualify it) -----------
  always_ff @(posedge clk) begin
    if (svm_enable) begin
      a_mag    <= mag(mul_a);
      b_mag    <= mag(mul_b);
      sgn_pipe <= {sgn_pipe[T:0], mul_a[DATA_W-1] ^ mul_b[DATA_W-1]};
      for (int i = 0; i < DATA_W; i++)
        tree[0][i] <= b_mag[i] ? (PW'(a_mag) << i) : '0;
      tree[0][DATA_W] <= '0;
      for (int l = 1; l <= T; l++) begin
        for (int j = 0; j < HALF; j++) begin
          if (j >= lvl_cnt(l))                tree[l][j] <= '0;
          else if (2*j + 1 < lvl_cnt(l - 1))  tree[l][j] <= tree[l-1][2*j] + tree[l-1][2*j+1];
          else                                tree[l][j] <= tree[l-1][2*j];
        end
        for (int j = HALF; j <= DATA_W; j++)
          tree[l][j] <= '0;
      end
      // Zero magnitude stays +0 regardless of operand signs.
      if (sgn_pipe[T+1] && (|tree[T][0])) prod_s <= -$signed(tree[T][0]);
      else                                prod_s <= $signed(tree[T][0]);
    end
  end

  // ---------------- round half toward +inf, then clamp --------------------
  always_comb begin
    ext     = XW'(prod_s) + RND;
    shf     = ext >>> FRAC_SHIFT;
    rnd_sat = 1'b0;
    rnd_q   = shf[OUT_W-1:0];
    if (shf > SAT_MAX) begin
      rnd_q   = SAT_MAX[OUT_W-1:0];
      rnd_sat = 1'b1;
    end else if (shf < SAT_MIN) begin
      rnd_q   = SAT_MIN[OUT_W-1:0];
      rnd_sat = 1'b1;
    end
  end

  // ---------------- accumulate with saturation ----------------------------
  always_comb begin
    sum       = (OUT_W+1)'(acc) + (OUT_W+1)'($signed(prod_data));
    acc_nx    = sum[OUT_W-1:0];
    acc_clamp = 1'b0;
    if (sum[OUT_W] != sum[OUT_W-1]) begin
      acc_nx    = sum[OUT_W] ? ACC_MIN : ACC_MAX;
      acc_clamp = 1'b1;
    end
    flag_nx = acc_flag | prod_sat | acc_clamp;
  end

  // ---------------- control, tags and outputs -----------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      prod_data <= '0;
      prod_sat  <= 1'b0;
      acc       <= '0;
      acc_flag  <= 1'b0;
      vec_open  <= 1'b0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_sat   <= 1'b0;
    end else if (svm_enable) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
      tag_pipe  <= {tag_pipe[STAGES-1:0], tag_t'{last: in_last, mode: in_mode}};
      prod_data <= rnd_q;
      prod_sat  <= rnd_sat;
      acc_valid <= 1'b0;
      if (vld_pipe[STAGES] && tag_pipe[STAGES].mode) begin
        if (tag_pipe[STAGES].last) begin
          // Report and clear together so the next vector starts at 0.
          acc_data  <= acc_nx;
          acc_sat   <= flag_nx;
          acc_valid <= 1'b1;
          acc       <= '0;
          acc_flag  <= 1'b0;
          vec_open  <= 1'b0;
        end else begin
          acc       <= acc_nx;
          acc_flag  <= flag_nx;
          vec_open  <= 1'b1;
        end
      end
    end
  end

  assign prod_valid = vld_pipe[STAGES];
  assign busy       = (|vld_pipe) | vec_open;

endmodule

// File: tb/tb_svm_mac_pipe.sv
module tb_svm_mac_pipe;
  localparam int DW = 17;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst, svm_enable, in_valid, in_last, in_mode;
  logic [DW-1:0] mul_a, mul_b;
  logic prod_valid, acc_valid, acc_sat, busy;
  logic [OW-1:0] prod_data, acc_data;
  logic prod_valid8, acc_valid8, acc_sat8, busy8;
  logic [OW-1:0] prod_data8, acc_data8;

  svm_mac_pipe dut (
    .clk(clk), .rst(rst), .svm_enable(svm_enable), .in_valid(in_valid),
    .in_last(in_last), .in_mode(in_mode), .mul_a(mul_a), .mul_b(mul_b),
    .prod_valid(prod_valid), .prod_data(prod_data), .acc_valid(acc_valid),
    .acc_data(acc_data), .acc_sat(acc_sat), .busy(busy));

  svm_mac_pipe #(.FRAC_SHIFT(8)) dut8 (
    .clk(clk), .rst(rst), .svm_enable(svm_enable), .in_valid(in_valid),
    .in_last(in_last), .in_mode(in_mode), .mul_a(mul_a), .mul_b(mul_b),
    .prod_valid(prod_valid8), .prod_data(prod_data8), .acc_valid(acc_valid8),
    .acc_data(acc_data8), .acc_sat(acc_sat8), .busy(busy8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int          pc[$], ac[$], p8c[$];
  logic [31:0] pd[$], ad[$], p8d[$];
  logic        asq[$];

  always @(negedge clk) begin
    if (prod_valid)  begin pc.push_back(cyc);  pd.push_back(prod_data); end
    if (acc_valid)   begin ac.push_back(cyc);  ad.push_back(acc_data); asq.push_back(acc_sat); end
    if (prod_valid8) begin p8c.push_back(cyc); p8d.push_back(prod_data8); end
  end

  task automatic clrq();
    pc.delete(); pd.delete(); ac.delete(); ad.delete(); asq.delete();
    p8c.delete(); p8d.delete();
  endtask

  task automatic step(input logic v, input logic l, input logic m, input int a, input int b);
    in_valid = v; in_last = l; in_mode = m;
    mul_a = a[DW-1:0]; mul_b = b[DW-1:0];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; svm_enable = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0; mul_a = '0; mul_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (prod_valid !== 1'b0) begin n_bad++; $display("FAIL rst_prod_valid got %b want 0", prod_valid); end
    n_cmp++; if (prod_data !== 32'd0) begin n_bad++; $display("FAIL rst_prod_data got %h want 0", prod_data); end
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_acc_valid got %b want 0", acc_valid); end
    n_cmp++; if (acc_data !== 32'd0) begin n_bad++; $display("FAIL rst_acc_data got %h want 0", acc_data); end
    n_cmp++; if (acc_sat !== 1'b0) begin n_bad++; $display("FAIL rst_acc_sat got %b want 0", acc_sat); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_mul();
    int t0;
    clrq();
    t0 = cyc;
    step(1, 0, 0, 3, -5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mul_busy got %b want 1", busy); end
    idle(14);
    n_cmp++; if (pc.size() != 1) begin n_bad++; $display("FAIL mul_count got %0d want 1", pc.size()); end
    n_cmp++; if (pc.size() < 1 || pc[0] != t0 + 9) begin n_bad++; $display("FAIL mul_latency got %0d want %0d", (pc.size() > 0) ? pc[0] - t0 : -1, 9); end
    n_cmp++; if (pd.size() < 1 || pd[0] !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mul_data got %h want fffffff1", (pd.size() > 0) ? pd[0] : 32'hx); end
    n_cmp++; if (ac.size() != 0) begin n_bad++; $display("FAIL mul_no_acc got %0d strobes want 0", ac.size()); end
  endtask

  task automatic test_sat();
    int t0;
    clrq();
    t0 = cyc;
    step(1, 0, 0, -65536, -65536);
    step(1, 0, 0, -65536, 65535);
    step(1, 1, 1, -65536, -65536);
    idle(16);
    n_cmp++; if (pc.size() != 3) begin n_bad++; $display("FAIL sat_count got %0d want 3", pc.size()); end
    n_cmp++; if (pd.size() < 1 || pd[0] !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sat_pos got %h want 7fffffff", (pd.size() > 0) ? pd[0] : 32'hx); end
    n_cmp++; if (pd.size() < 2 || pd[1] !== 32'h8000_0000) begin n_bad++; $display("FAIL sat_neg got %h want 80000000", (pd.size() > 1) ? pd[1] : 32'hx); end
    n_cmp++; if (pc.size() < 2 || pc[1] != t0 + 10) begin n_bad++; $display("FAIL sat_throughput got %0d want %0d", (pc.size() > 1) ? pc[1] : -1, t0 + 10); end
    n_cmp++; if (ac.size() < 1 || ac[0] != t0 + 12) begin n_bad++; $display("FAIL sat_single_cyc got %0d want %0d", (ac.size() > 0) ? ac[0] : -1, t0 + 12); end
    n_cmp++; if (ad.size() < 1 || ad[0] !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sat_single_data got %h want 7fffffff", (ad.size() > 0) ? ad[0] : 32'hx); end
    n_cmp++; if (asq.size() < 1 || asq[0] !== 1'b1) begin n_bad++; $display("FAIL sat_single_flag got %b want 1", (asq.size() > 0) ? asq[0] : 1'bx); end
  endtask

  task automatic test_round();
    clrq();
    step(1, 0, 0, 384, 1);
    step(1, 0, 0, -384, 1);
    step(1, 0, 0, 128, 1);
    step(1, 0, 0, 127, 1);
    idle(14);
    n_cmp++; if (p8d.size() != 4) begin n_bad++; $display("FAIL rnd_count got %0d want 4", p8d.size()); end
    n_cmp++; if (p8d.size() < 1 || p8d[0] !== 32'd2) begin n_bad++; $display("FAIL rnd_384 got %h want 2", (p8d.size() > 0) ? p8d[0] : 32'hx); end
    n_cmp++; if (p8d.size() < 2 || p8d[1] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rnd_m384 got %h want ffffffff", (p8d.size() > 1) ? p8d[1] : 32'hx); end
    n_cmp++; if (p8d.size() < 3 || p8d[2] !== 32'd1) begin n_bad++; $display("FAIL rnd_128 got %h want 1", (p8d.size() > 2) ? p8d[2] : 32'hx); end
    n_cmp++; if (p8d.size() < 4 || p8d[3] !== 32'd0) begin n_bad++; $display("FAIL rnd_127 got %h want 0", (p8d.size() > 3) ? p8d[3] : 32'hx); end
    n_cmp++; if (pd.size() < 2 || pd[1] !== 32'hFFFF_FE80) begin n_bad++; $display("FAIL rnd_unscaled got %h want fffffe80", (pd.size() > 1) ? pd[1] : 32'hx); end
  endtask

  task automatic test_back_to_back();
    int t0;
    clrq();
    t0 = cyc;
    step(1, 0, 1, 2, 3);
    step(1, 0, 1, 4, 5);
    step(1, 1, 1, -1, 7);
    step(1, 1, 1, 10, 10);
    idle(16);
    n_cmp++; if (ac.size() != 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", ac.size()); end
    n_cmp++; if (ad.size() < 1 || ad[0] !== 32'd19) begin n_bad++; $display("FAIL b2b_sum0 got %0d want 19", (ad.size() > 0) ? ad[0] : 32'hx); end
    n_cmp++; if (ad.size() < 2 || ad[1] !== 32'd100) begin n_bad++; $display("FAIL b2b_sum1 got %0d want 100", (ad.size() > 1) ? ad[1] : 32'hx); end
    n_cmp++; if (ac.size() < 2 || ac[0] != t0 + 12 || ac[1] != t0 + 13) begin n_bad++; $display("FAIL b2b_cycles got %0d,%0d want %0d,%0d", (ac.size() > 0) ? ac[0] : -1, (ac.size() > 1) ? ac[1] : -1, t0 + 12, t0 + 13); end
    n_cmp++; if (asq.size() < 2 || asq[0] !== 1'b0 || asq[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_sat got %0d flags want 0,0", asq.size()); end
    n_cmp++; if (acc_data !== 32'd100) begin n_bad++; $display("FAIL b2b_hold got %0d want 100", acc_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    int t0;
    clrq();
    t0 = cyc;
    step(1, 0, 1, 2, 3);
    step(1, 0, 1, 4, 5);
    svm_enable = 1'b0;
    // Junk presented while frozen must be ignored.
    step(1, 1, 1, 999, 999);
    step(1, 1, 1, -7, 3);
    step(1, 0, 0, 5, 5);
    svm_enable = 1'b1;
    step(1, 1, 1, -1, 7);
    step(1, 1, 1, 10, 10);
    idle(16);
    n_cmp++; if (ac.size() != 2) begin n_bad++; $display("FAIL stall_count got %0d want 2", ac.size()); end
    n_cmp++; if (ad.size() < 2 || ad[0] !== 32'd19 || ad[1] !== 32'd100) begin n_bad++; $display("FAIL stall_sums got %0d,%0d want 19,100", (ad.size() > 0) ? ad[0] : 32'hx, (ad.size() > 1) ? ad[1] : 32'hx); end
    n_cmp++; if (ac.size() < 2 || ac[0] != t0 + 15 || ac[1] != t0 + 16) begin n_bad++; $display("FAIL stall_delay got %0d,%0d want %0d,%0d", (ac.size() > 0) ? ac[0] : -1, (ac.size() > 1) ? ac[1] : -1, t0 + 15, t0 + 16); end
    n_cmp++; if (pc.size() != 4) begin n_bad++; $display("FAIL stall_prod_count got %0d want 4", pc.size()); end
  endtask

  task automatic test_reset_mid();
    clrq();
    for (int i = 0; i < 5; i++) step(1, 0, 1, i + 1, 2);
    idle(3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    clrq();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(15);
    n_cmp++; if (pc.size() != 0 || ac.size() != 0) begin n_bad++; $display("FAIL rmid_strobes got %0d prod %0d acc want 0", pc.size(), ac.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_after got %b want 0", busy); end
    n_cmp++; if (acc_data !== 32'd0) begin n_bad++; $display("FAIL rmid_acc_data got %0d want 0", acc_data); end
    step(1, 0, 1, 3, 4);
    step(1, 1, 1, 5, 6);
    idle(14);
    n_cmp++; if (ad.size() != 1 || ad[0] !== 32'd42) begin n_bad++; $display("FAIL rmid_next_sum got %0d (n=%0d) want 42", (ad.size() > 0) ? ad[0] : 32'hx, ad.size()); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_sat();
    test_round();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
